// File: rtl/vx_raster_tile_sched.sv
// Raster tile scheduler: streams tile entries from a tile buffer in memory
// into a small FIFO and hands them out round-robin to the raster slices.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; a zero-tile start just pulses done
// S_RUN  | fetching tile entries and dispatching them to slices
module vx_raster_tile_sched #(
    parameter int NUM_SLICES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           tbuf_addr,
    input  logic [15:0]           tile_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req_valid,
    output logic [31:0]           mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    output logic                  mem_rsp_ready,
    output logic [NUM_SLICES-1:0] tile_valid,
    output logic [31:0]           tile_data,
    input  logic [NUM_SLICES-1:0] tile_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [15:0]       total_q, total_d;
    logic [15:0]       req_idx_q, req_idx_d;
    logic [15:0]       disp_cnt_q, disp_cnt_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic              done_q, done_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];

    logic              fifo_empty;
    logic              grant_found;
    logic [RR_W-1:0]   grant_idx;
    logic              req_fire;
    logic              rsp_fire;
    logic              disp_fire;
    logic [CNT_W:0]    credit_used;

    // (p + k) mod NUM_SLICES, with k < NUM_SLICES so one subtraction suffices
    function automatic logic [RR_W-1:0] slice_add(input logic [RR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_SLICES) s = s - NUM_SLICES;
        return RR_W'(s);
    endfunction

    // Round-robin grant: first ready slice at or after the pointer
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_q;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (!grant_found && tile_ready[slice_add(rr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = slice_add(rr_q, i);
            end
        end
    end

    // Datapath outputs; every response lands in the FIFO, so in-flight
    // reads plus stored entries must never exceed the FIFO depth
    always_comb begin
        fifo_empty  = (occ_q == '0);
        credit_used = {1'b0, outst_q} + {1'b0, occ_q};
        disp_fire   = !fifo_empty && grant_found;
        tile_valid  = '0;
        if (disp_fire) tile_valid[grant_idx] = 1'b1;
        tile_data     = fifo_empty ? 32'd0 : fifo_mem_q[rd_ptr_q];
        mem_req_valid = (state_q == S_RUN) && (req_idx_q < total_q)
                        && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        mem_req_addr  = base_q + {14'd0, req_idx_q, 2'b00};
        mem_rsp_ready = 1'b1;
        req_fire      = mem_req_valid && mem_req_ready;
        rsp_fire      = mem_rsp_valid;
        busy          = (state_q == S_RUN);
        done          = done_q;
    end

    // Next-state: FSM, counters, FIFO bookkeeping and round-robin pointer
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        base_d     = base_q;
        total_d    = total_q;
        req_idx_d  = req_idx_q + {15'd0, req_fire};
        disp_cnt_d = disp_cnt_q + {15'd0, disp_fire};
        wr_ptr_d   = wr_ptr_q + PTR_W'(rsp_fire);
        rd_ptr_d   = rd_ptr_q + PTR_W'(disp_fire);
        rr_d       = disp_fire ? slice_add(grant_idx, 1) : rr_q;

        outst_d = outst_q;
        if (req_fire && !rsp_fire)      outst_d = outst_q + CNT_W'(1);
        else if (!req_fire && rsp_fire) outst_d = outst_q - CNT_W'(1);

        occ_d = occ_q;
        if (rsp_fire && !disp_fire)      occ_d = occ_q + CNT_W'(1);
        else if (!rsp_fire && disp_fire) occ_d = occ_q - CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (tile_count == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_RUN;
                        base_d     = tbuf_addr;
                        total_d    = tile_count;
                        req_idx_d  = 16'd0;
                        disp_cnt_d = 16'd0;
                    end
                end
            end
            S_RUN: begin
                if (disp_fire && (disp_cnt_q + 16'd1 == total_q)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            base_q     <= '0;
            total_q    <= '0;
            req_idx_q  <= '0;
            disp_cnt_q <= '0;
            outst_q    <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            base_q     <= base_d;
            total_q    <= total_d;
            req_idx_q  <= req_idx_d;
            disp_cnt_q <= disp_cnt_d;
            outst_q    <= outst_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rr_q       <= rr_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (rsp_fire) fifo_mem_q[wr_ptr_q] <= mem_rsp_data;
    end

endmodule

// File: tb/tb_vx_raster_tile_sched.sv
// Directed bench for vx_raster_tile_sched with an in-order memory model.
module tb_vx_raster_tile_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tbuf_addr = '0;
    logic [15:0] tile_count = '0;
    logic        busy, done;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_ready;
    logic [1:0]  tile_valid;
    logic [31:0] tile_data;
    logic [1:0]  tile_ready = 2'b00;

    int          chk = 0;
    int          pass = 0;
    logic [31:0] pend_q[$];
    logic [31:0] req_log[$];
    int          disp_slice[$];
    logic [31:0] disp_data[$];
    int          done_cnt = 0;
    int          busy_done_err = 0;
    int          onehot_err = 0;
    bit          rsp_en = 1'b1;

    vx_raster_tile_sched #(.NUM_SLICES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .tbuf_addr(tbuf_addr), .tile_count(tile_count),
        .busy(busy), .done(done),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
        .tile_valid(tile_valid), .tile_data(tile_data), .tile_ready(tile_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model and monitor, all on the falling edge
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
            end else begin
                if (rsp_en && pend_q.size() > 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(pend_q.pop_front());
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = '0;
                end
                if (mem_req_valid && mem_req_ready) begin
                    pend_q.push_back(mem_req_addr);
                    req_log.push_back(mem_req_addr);
                end
                for (int s = 0; s < 2; s++) begin
                    if (tile_valid[s] && tile_ready[s]) begin
                        disp_slice.push_back(s);
                        disp_data.push_back(tile_data);
                    end
                end
                if ($countones(tile_valid) > 1) onehot_err++;
                if (done) done_cnt++;
                if (done && busy) busy_done_err++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        disp_slice.delete();
        disp_data.delete();
        done_cnt = 0;
        busy_done_err = 0;
        onehot_err = 0;
    endtask

    task automatic pulse_start(input logic [31:0] addr, input logic [15:0] cnt);
        tbuf_addr  = addr;
        tile_count = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit got);
        int n = 0;
        while (done_cnt == 0 && n < max) begin
            tick();
            n++;
        end
        got = (done_cnt != 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass++;
        chk++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass++;
        chk++; if (mem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); else pass++;
        chk++; if (tile_valid !== 2'b00) $display("FAIL rst_tile_valid: got %b want 00", tile_valid); else pass++;
        chk++; if (mem_rsp_ready !== 1'b1) $display("FAIL rst_rsp_ready: got %b want 1", mem_rsp_ready); else pass++;
        reset = 1'b0;
        tick();
        chk++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", busy); else pass++;
    endtask

    task automatic test_basic();
        logic [31:0] exp_a[3] = '{32'h1000, 32'h1004, 32'h1008};
        int          exp_s[3] = '{0, 1, 0};
        bit          got;
        clear_logs();
        tile_ready = 2'b11;
        mem_req_ready = 1'b1;
        pulse_start(32'h1000, 16'd3);
        chk++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else pass++;
        wait_done(100, got);
        chk++; if (!got) $display("FAIL basic_timeout: done not seen within 100 cycles"); else pass++;
        chk++; if (req_log.size() != 3) $display("FAIL basic_nreq: got %0d want 3", req_log.size()); else pass++;
        for (int i = 0; i < 3; i++) begin
            chk++; if (req_log[i] !== exp_a[i]) $display("FAIL basic_addr%0d: got %h want %h", i, req_log[i], exp_a[i]); else pass++;
            chk++; if (disp_slice[i] != exp_s[i]) $display("FAIL basic_slice%0d: got %0d want %0d", i, disp_slice[i], exp_s[i]); else pass++;
            chk++; if (disp_data[i] !== mem_word(exp_a[i])) $display("FAIL basic_data%0d: got %h want %h", i, disp_data[i], mem_word(exp_a[i])); else pass++;
        end
        chk++; if (done_cnt != 1) $display("FAIL basic_done_cycles: got %0d want 1", done_cnt); else pass++;
        chk++; if (busy_done_err != 0) $display("FAIL basic_busy_with_done: got %0d want 0", busy_done_err); else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else pass++;
        chk++; if (onehot_err != 0) $display("FAIL basic_onehot: got %0d want 0", onehot_err); else pass++;
    endtask

    task automatic test_zero();
        clear_logs();
        tile_ready = 2'b11;
        pulse_start(32'h1000, 16'd0);
        chk++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else pass++;
        chk++; if (mem_req_valid !== 1'b0) $display("FAIL zero_req: got %b want 0", mem_req_valid); else pass++;
        tick();
        chk++; if (done !== 1'b0) $display("FAIL zero_done_drop: got %b want 0", done); else pass++;
        repeat (3) tick();
        chk++; if (req_log.size() != 0) $display("FAIL zero_nreq: got %0d want 0", req_log.size()); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL zero_done_cycles: got %0d want 1", done_cnt); else pass++;
    endtask

    task automatic test_backpressure();
        bit got;
        clear_logs();
        tile_ready = 2'b00;
        pulse_start(32'h2000, 16'd10);
        repeat (30) tick();
        chk++; if (req_log.size() != 4) $display("FAIL bp_nreq_stalled: got %0d want 4", req_log.size()); else pass++;
        chk++; if (mem_req_valid !== 1'b0) $display("FAIL bp_req_valid: got %b want 0", mem_req_valid); else pass++;
        chk++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else pass++;
        chk++; if (disp_slice.size() != 0) $display("FAIL bp_ndisp_stalled: got %0d want 0", disp_slice.size()); else pass++;
        tile_ready = 2'b11;
        wait_done(200, got);
        chk++; if (!got) $display("FAIL bp_timeout: done not seen within 200 cycles"); else pass++;
        chk++; if (req_log.size() != 10) $display("FAIL bp_nreq: got %0d want 10", req_log.size()); else pass++;
        chk++; if (req_log[9] !== 32'h2024) $display("FAIL bp_last_addr: got %h want 00002024", req_log[9]); else pass++;
        chk++; if (disp_data.size() != 10) $display("FAIL bp_ndisp: got %0d want 10", disp_data.size()); else pass++;
        for (int i = 0; i < 10; i++) begin
            chk++;
            if (disp_data[i] !== mem_word(32'h2000 + 32'(4*i)))
                $display("FAIL bp_data%0d: got %h want %h", i, disp_data[i], mem_word(32'h2000 + 32'(4*i)));
            else pass++;
        end
        chk++; if (done_cnt != 1) $display("FAIL bp_done_cycles: got %0d want 1", done_cnt); else pass++;
    endtask

    task automatic test_one_slice();
        bit got;
        int n0 = 0;
        int n1 = 0;
        clear_logs();
        tile_ready = 2'b10;
        pulse_start(32'h3000, 16'd3);
        wait_done(100, got);
        chk++; if (!got) $display("FAIL s1_timeout: done not seen within 100 cycles"); else pass++;
        foreach (disp_slice[i]) begin
            if (disp_slice[i] == 0) n0++;
            if (disp_slice[i] == 1) n1++;
        end
        chk++; if (n0 != 0) $display("FAIL s1_slice0_grants: got %0d want 0", n0); else pass++;
        chk++; if (n1 != 3) $display("FAIL s1_slice1_grants: got %0d want 3", n1); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL s1_done_cycles: got %0d want 1", done_cnt); else pass++;
    endtask

    task automatic test_wrap_latch();
        bit got;
        clear_logs();
        tile_ready = 2'b01;
        pulse_start(32'hFFFF_FFFC, 16'd2);
        tbuf_addr  = 32'h5000;
        tile_count = 16'd7;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_done(100, got);
        chk++; if (!got) $display("FAIL wrap_timeout: done not seen within 100 cycles"); else pass++;
        chk++; if (req_log.size() != 2) $display("FAIL wrap_nreq: got %0d want 2", req_log.size()); else pass++;
        chk++; if (req_log[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", req_log[0]); else pass++;
        chk++; if (req_log[1] !== 32'h0000_0000) $display("FAIL wrap_addr1: got %h want 00000000", req_log[1]); else pass++;
        chk++; if (disp_data[1] !== mem_word(32'h0)) $display("FAIL wrap_data1: got %h want %h", disp_data[1], mem_word(32'h0)); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL wrap_done_cycles: got %0d want 1", done_cnt); else pass++;
        tile_count = 16'd0;
    endtask

    task automatic test_reset_mid();
        bit got;
        clear_logs();
        rsp_en = 1'b0;
        tile_ready = 2'b00;
        mem_req_ready = 1'b0;
        pulse_start(32'h6000, 16'd5);
        mem_req_ready = 1'b1;
        tick(); tick();
        mem_req_ready = 1'b0;
        chk++; if (req_log.size() != 2) $display("FAIL mid_nreq: got %0d want 2", req_log.size()); else pass++;
        chk++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else pass++;
        #2 reset = 1'b1;
        #1;
        chk++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else pass++;
        chk++; if (done !== 1'b0) $display("FAIL mid_done: got %b want 0", done); else pass++;
        chk++; if (mem_req_valid !== 1'b0) $display("FAIL mid_req_valid: got %b want 0", mem_req_valid); else pass++;
        chk++; if (mem_req_addr !== 32'h0) $display("FAIL mid_req_addr: got %h want 00000000", mem_req_addr); else pass++;
        chk++; if (tile_valid !== 2'b00) $display("FAIL mid_tile_valid: got %b want 00", tile_valid); else pass++;
        chk++; if (tile_data !== 32'h0) $display("FAIL mid_tile_data: got %h want 00000000", tile_data); else pass++;
        tick(); tick();
        reset = 1'b0;
        rsp_en = 1'b1;
        mem_req_ready = 1'b1;
        tile_ready = 2'b11;
        tick();
        clear_logs();
        pulse_start(32'h4000, 16'd1);
        wait_done(100, got);
        chk++; if (!got) $display("FAIL mid_timeout: done not seen within 100 cycles"); else pass++;
        chk++; if (req_log.size() != 1) $display("FAIL mid_post_nreq: got %0d want 1", req_log.size()); else pass++;
        chk++; if (req_log[0] !== 32'h4000) $display("FAIL mid_post_addr: got %h want 00004000", req_log[0]); else pass++;
        chk++; if (disp_slice[0] != 0) $display("FAIL mid_post_slice: got %0d want 0", disp_slice[0]); else pass++;
        chk++; if (disp_data[0] !== mem_word(32'h4000)) $display("FAIL mid_post_data: got %h want %h", disp_data[0], mem_word(32'h4000)); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL mid_post_done_cycles: got %0d want 1", done_cnt); else pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_one_slice();
        test_wrap_latch();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", pass, chk);
        $fatal(1);
    end

endmodule
